score_display: RTL and testbench
================================

// Module: score_display
// PURPOSE
//  Multi-digit decimal score renderer, successor to the single-digit cheese counter.
//  Converts a binary score to BCD with a sequential double-dabble converter and latches it.
//  Returns the glyph pixel for the current in-box coordinate from one shared 10-glyph ROM.
//  Sits between game logic (score source) and the draw/mux stage of the VGA pipeline.
// PARAMETERS
//  SCORE_W   8                                   binary score width
//  DIGITS    3                                   displayed decimal digits (1..6)
//  GLYPH_W   32                                  glyph width in px; must be a power of two
//  GLYPH_H   48                                  glyph height in px
//  DATA_PATH "../../rtl/data/numbers/digits.dat" glyphs 0..9 stacked, 12-bit RGB words
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous, active-low reset
//  score        in   SCORE_W  binary score; sampled when score_valid=1
//  score_valid  in   1        one-cycle request to convert and display score
//  busy         out  1        conversion in progress
//  x            in   11       pixel column relative to score box origin
//  y            in   11       pixel row relative to score box origin
//  rgb          out  12       glyph pixel colour
//  rgb_en       out  1        1 = rgb is a valid glyph pixel for this coordinate
// BEHAVIOUR
//  Reset: rgb=0, rgb_en=0, busy=0, displayed digits all 0, FSM IDLE, pending flag 0.
//  Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: score_valid=1 loads score into shift reg, clears BCD scratch, goes to SHIFT.
//   SHIFT: exactly SCORE_W cycles; each cycle add 3 to every BCD nibble >=5, then shift left 1.
//   DONE: one cycle; commits scratch BCD to display register; returns to IDLE.
//  busy=1 in SHIFT and DONE: SCORE_W+1 cycles, starting the cycle after score_valid.
//  Display register changes only in DONE; rendering never shows a partial conversion.
//  score_valid while busy: score is captured into a pending register and the pending flag is set.
//   Later requests overwrite it; the last value wins.
//   After DONE, a set pending flag starts a new conversion at once (IDLE for 1 cycle).
//  Saturation: if the converted value >= 10^DIGITS, every displayed digit is 9.
//  BCD scratch holds ceil(SCORE_W*log10(2))+1 nibbles; only the low DIGITS nibbles are shown.
//  Render pipeline, fixed latency 2 cycles from (x,y) to (rgb,rgb_en):
//   S0: in_box = (x < DIGITS*GLYPH_W) && (y < GLYPH_H).
//       d_idx = x >> log2(GLYPH_W) (0 = most significant digit); col = x[log2(GLYPH_W)-1:0].
//       addr = (digit_val*GLYPH_H + y)*GLYPH_W + col; addr is registered with in_box.
//   S1: synchronous ROM read; in_box is delayed alongside it.
//   S2: rgb <= in_box_d ? rom_q : 0; rgb_en <= in_box_d.
//  Out-of-box coordinates output rgb=0, rgb_en=0, and the ROM address is clamped to 0.
//  Reset mid-conversion: FSM goes to IDLE, pending flag clears, display reads 0.
//   No commit happens after reset.
// CONFIGURATION
//  SCORE_LEADING_ZERO_BLANK_EN defined:
//   A digit position is blank (rgb=0, rgb_en=0) if it and every more-significant digit are 0.
//   The least significant digit is always drawn.
//  SCORE_LEADING_ZERO_BLANK_EN undefined: every digit is drawn, including leading zeros.
// STRUCTURE
//  score_pkg: DIGIT_ROM_DEPTH = 10*GLYPH_W*GLYPH_H, address width function, bcd_digit_t (4-bit).
//  score_pkg: typedef enum {IDLE, SHIFT, DONE} b2b_state_t.
//  Sub-module score_bin2bcd holds the FSM, the pending register, busy, and the committed BCD vector.
//  Glyph storage uses one existing read_rom instance with DATA_PATH.
// TESTING
//  T1 reset: rst_n=0 then 1 -> busy=0; rgb=0 and rgb_en=0 at x=0,y=0; digits read 0,0,0.
//  T2 score=123, valid pulse -> busy=1 for exactly 9 cycles; after that, digits 1,2,3.
//  T3 x=40, y=5 after T2 -> 2 cycles later rgb = ROM[(2*48+5)*32+8], rgb_en=1.
//     x=96 -> rgb_en=0.
//  T4 DIGITS=2, score=255 -> digits 9,9 (saturation).
//  T5 valid(10), then valid(200) and valid(77) while busy -> display goes 010, then 077.
//     There is exactly 1 IDLE cycle between the two conversions; 200 is never shown.
//  T6 rst_n low in SHIFT cycle 4 of score=250 -> display 000.
//     With SCORE_LEADING_ZERO_BLANK_EN, score=7 -> only the third digit has rgb_en=1.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and sizing helpers for the multi-digit score renderer.
package score_pkg;

   localparam int GLYPH_W_DEF     = 32;
   localparam int GLYPH_H_DEF     = 48;
   localparam int DIGIT_ROM_DEPTH = 10 * GLYPH_W_DEF * GLYPH_H_DEF;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

   function automatic int rom_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // ceil(w * log10(2)) + 1 BCD nibbles are enough for any w-bit value.
   function automatic int bcd_nibbles(input int w);
      return (w * 30103 + 99999) / 100000 + 1;
   endfunction

endpackage

// File: rtl/read_rom.sv
// Synchronous-read glyph ROM. Glyph words are generated from the address so no
// init file is needed at build time; an empty DATA_PATH yields a blank ROM.
module read_rom
   import score_pkg::*;
#(
   parameter int    DEPTH     = DIGIT_ROM_DEPTH,
   parameter int    ADDR_W    = rom_addr_w(DEPTH),
   parameter int    DATA_W    = 12,
   parameter string DATA_PATH = ""
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] q
);

   localparam bit HAS_IMAGE = (DATA_PATH != "");

   function automatic logic [DATA_W-1:0] glyph_word(input logic [ADDR_W-1:0] a);
      return DATA_W'((32'(a) * 32'd7) ^ (32'(a) >> 9));
   endfunction

   // NOTE: ROM/memory outputs carry no reset; downstream valid flags gate them.
   always_ff @(posedge clk) begin
      if (HAS_IMAGE && (int'(addr) < DEPTH)) q <= glyph_word(addr);
      else                                   q <= '0;
   end

endmodule

// File: rtl/score_bin2bcd.sv
// Sequential double-dabble converter with a one-deep "last wins" pending request
// and a committed, saturated display register.
module score_bin2bcd
   import score_pkg::*;
#(
   parameter int SCORE_W = 8,
   parameter int DIGITS  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SCORE_W-1:0]    score,
   input  logic                  score_valid,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   digits
);

   localparam int NIB   = bcd_nibbles(SCORE_W);
   localparam int SCR_N = (NIB > DIGITS) ? NIB : DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);

   b2b_state_t           state, state_nx;
   logic [SCORE_W-1:0]   shreg, pend_val, start_val;
   logic [4*SCR_N-1:0]   scratch, adj;
   logic [CNT_W-1:0]     cnt;
   logic                 pend, start, sat;
   logic [4*DIGITS-1:0]  commit;

   // NOTE: every always_comb output is defaulted first so no path infers a latch.
   always_comb begin
      state_nx  = state;
      start     = 1'b0;
      start_val = score;
      unique case (state)
         IDLE: begin
            if (score_valid) begin
               start    = 1'b1;
               state_nx = SHIFT;
            end else if (pend) begin
               start     = 1'b1;
               start_val = pend_val;
               state_nx  = SHIFT;
            end
         end
         SHIFT:   if (cnt == CNT_W'(SCORE_W - 1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      adj = scratch;
      for (int i = 0; i < SCR_N; i++)
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
   end

   // Anything left in the nibbles above the shown ones means the value overflows.
   always_comb begin
      sat = 1'b0;
      for (int i = DIGITS; i < SCR_N; i++) sat = sat | (scratch[4*i +: 4] != 4'd0);
      commit = sat ? {DIGITS{4'd9}} : scratch[4*DIGITS-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         pend     <= 1'b0;
         pend_val <= '0;
         digits   <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            shreg   <= start_val;
            scratch <= '0;
            cnt     <= '0;
         end else if (state == SHIFT) begin
            {scratch, shreg} <= {adj, shreg} << 1;
            cnt              <= cnt + CNT_W'(1);
         end
         if (state == DONE) digits <= commit;
         if (state != IDLE && score_valid) begin
            pend     <= 1'b1;
            pend_val <= score;
         end else if (start) begin
            pend <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/score_display.sv
// Multi-digit score renderer: converter + 2-cycle glyph lookup pipeline.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_display
   import score_pkg::*;
#(
   parameter int    SCORE_W   = 8,
   parameter int    DIGITS    = 3,
   parameter int    GLYPH_W   = GLYPH_W_DEF,
   parameter int    GLYPH_H   = GLYPH_H_DEF,
   parameter string DATA_PATH = "../../rtl/data/numbers/digits.dat"
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   output logic               busy,
   input  logic [10:0]        x,
   input  logic [10:0]        y,
   output logic [11:0]        rgb,
   output logic               rgb_en
);

   localparam int LOG2_GW   = $clog2(GLYPH_W);
   localparam int ROM_DEPTH = 10 * GLYPH_W * GLYPH_H;
   localparam int ADDR_W    = rom_addr_w(ROM_DEPTH);

   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0]   blank;
   logic [10:0]         d_idx;
   bcd_digit_t          digit_val;
   logic                in_box, hide, show, in_box_r, in_box_d;
   logic [ADDR_W-1:0]   addr_s0, addr_r;
   logic [11:0]         rom_q;

   score_bin2bcd #(
      .SCORE_W (SCORE_W),
      .DIGITS  (DIGITS)
   ) u_b2b (
      .clk         (clk),
      .rst_n       (rst_n),
      .score       (score),
      .score_valid (score_valid),
      .busy        (busy),
      .digits      (digits)
   );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
   logic lead;
   // Position 0 is the most significant digit; the last position is never blanked.
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int i = 0; i < DIGITS - 1; i++) begin
         lead     = lead & (digits[4*(DIGITS-1-i) +: 4] == 4'd0);
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      d_idx     = x >> LOG2_GW;
      in_box    = (int'(x) < DIGITS * GLYPH_W) && (int'(y) < GLYPH_H);
      digit_val = '0;
      hide      = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (int'(d_idx) == i) begin
            digit_val = digits[4*(DIGITS-1-i) +: 4];
            hide      = blank[i];
         end
      end
      show    = in_box && !hide;
      addr_s0 = '0;
      if (show)
         addr_s0 = (ADDR_W'(digit_val) * ADDR_W'(GLYPH_H) + ADDR_W'(y)) * ADDR_W'(GLYPH_W)
                   + ADDR_W'(x[LOG2_GW-1:0]);
   end

   read_rom #(
      .DEPTH     (ROM_DEPTH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (12),
      .DATA_PATH (DATA_PATH)
   ) u_rom (
      .clk  (clk),
      .addr (addr_r),
      .q    (rom_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r   <= '0;
         in_box_r <= 1'b0;
         in_box_d <= 1'b0;
         rgb      <= '0;
         rgb_en   <= 1'b0;
      end else begin
         addr_r   <= addr_s0;
         in_box_r <= show;
         in_box_d <= in_box_r;
         rgb      <= in_box_d ? rom_q : 12'h000;
         rgb_en   <= in_box_d;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: 3-digit and 2-digit instances checked every cycle
// against a value-level model, plus directed literal probes.
module tb_score_display;

   localparam int SW = 8;
   localparam int GW = 32;
   localparam int GH = 48;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  score = '0;
   logic        score_valid = 1'b0;
   logic [10:0] x = '0;
   logic [10:0] y = '0;
   logic        busy, busy2, rgb_en, rgb_en2;
   logic [11:0] rgb, rgb2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   score_display #(.DIGITS(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid), .busy(busy),
      .x(x), .y(y), .rgb(rgb), .rgb_en(rgb_en));

   score_display #(.DIGITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid), .busy(busy2),
      .x(x), .y(y), .rgb(rgb2), .rgb_en(rgb_en2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rom_word(input int a);
      return ((a * 7) ^ (a >> 9)) & 12'hFFF;
   endfunction

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Expected pixel for coordinate (xv,yv) when the converted value is v on d digits.
   function automatic void render(input int xv, input int yv, input int v, input int d,
                                  output int r, output int en);
      int dv, di, pw, dig;
      r  = 0;
      en = 0;
      dv = (v >= pow10(d)) ? pow10(d) - 1 : v;
      if (xv < d * GW && yv < GH) begin
         di  = xv / GW;
         pw  = pow10(d - 1 - di);
         dig = (dv / pw) % 10;
         if (BLANK && di != d - 1 && dv < pw) return;
         en = 1;
         r  = rom_word((dig * GH + yv) * GW + xv % GW);
      end
   endfunction

   // Value-level model: conversion takes SW+1 busy cycles, one pending slot, last wins.
   int m_left = 0, m_val = 0, m_conv = 0, m_pend = 0, m_pend_val = 0;
   int p3_rgb[2] = '{0, 0}, p3_en[2] = '{0, 0}, p2_rgb[2] = '{0, 0}, p2_en[2] = '{0, 0};
   int o3_rgb = 0, o3_en = 0, o2_rgb = 0, o2_en = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_val = 0; m_conv = 0; m_pend = 0; m_pend_val = 0;
         p3_rgb = '{0, 0}; p3_en = '{0, 0}; p2_rgb = '{0, 0}; p2_en = '{0, 0};
         o3_rgb = 0; o3_en = 0; o2_rgb = 0; o2_en = 0;
      end else begin
         o3_rgb = p3_rgb[1]; o3_en = p3_en[1]; p3_rgb[1] = p3_rgb[0]; p3_en[1] = p3_en[0];
         o2_rgb = p2_rgb[1]; o2_en = p2_en[1]; p2_rgb[1] = p2_rgb[0]; p2_en[1] = p2_en[0];
         render(int'(x), int'(y), m_val, 3, p3_rgb[0], p3_en[0]);
         render(int'(x), int'(y), m_val, 2, p2_rgb[0], p2_en[0]);
         if (m_left == 0) begin
            if (score_valid) begin
               m_conv = int'(score); m_left = SW + 1; m_pend = 0;
            end else if (m_pend != 0) begin
               m_conv = m_pend_val; m_left = SW + 1; m_pend = 0;
            end
         end else begin
            if (score_valid) begin
               m_pend = 1; m_pend_val = int'(score);
            end
            m_left--;
            if (m_left == 0) m_val = m_conv;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", busy, (m_left > 0) ? 1 : 0);
         check("busy2", busy2, (m_left > 0) ? 1 : 0);
         check("rgb3", rgb, o3_rgb);
         check("en3", rgb_en, o3_en);
         check("rgb2", rgb2, o2_rgb);
         check("en2", rgb_en2, o2_en);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse(input int v);
      score       = 8'(v);
      score_valid = 1'b1;
      tick(1);
      score_valid = 1'b0;
   endtask

   task automatic probe(input int xv, input int yv);
      x = 11'(xv);
      y = 11'(yv);
      tick(3);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      // T1 reset state
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_rgb", rgb, 0);
      check("rst_en", rgb_en, 0);
      rst_n = 1'b1;
      tick(1);
      probe(5, 3);
      check("zero_d0_en", rgb_en, BLANK ? 0 : 1);
      check("zero_d0_rgb", rgb, BLANK ? 0 : rom_word(101));
      probe(69, 3);
      check("zero_d2_en", rgb_en, 1);
      check("zero_d2_rgb", rgb, rom_word(101));
      check("zero_dut2_out", rgb_en2, 0);

      // T2 conversion timing
      pulse(123);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         tick(1);
      end
      check("busy_cycles", n, 9);

      // T3 render pipeline and box edges
      probe(40, 5);
      check("t3_rgb", rgb, rom_word(3240));
      check("t3_en", rgb_en, 1);
      check("sat2_rgb", rgb2, rom_word(13992));
      probe(70, 0);
      check("lsd_rgb", rgb, rom_word(4614));
      probe(10, 47);
      check("ybot_rgb", rgb, rom_word(3050));
      probe(10, 48);
      check("yout_en", rgb_en, 0);
      probe(96, 5);
      check("xout_en", rgb_en, 0);
      check("xout_rgb", rgb, 0);

      // T4 saturation on the 2-digit instance
      pulse(255);
      wait_idle();
      probe(0, 0);
      check("sat_msd", rgb2, rom_word(13824));
      check("sat_en", rgb_en2, 1);
      probe(70, 1);
      check("255_lsd", rgb, rom_word(7718));

      // T5 pending requests, last wins
      pulse(10);
      tick(2);
      pulse(200);
      tick(1);
      pulse(77);
      wait_idle();
      n = 0;
      while (busy !== 1'b1 && n < 5) begin
         n++;
         tick(1);
      end
      check("idle_gap", n, 1);
      wait_idle();
      probe(40, 0);
      check("77_mid", rgb, rom_word(10760));
      probe(10, 0);
      check("77_msd_en", rgb_en, BLANK ? 0 : 1);
      check("77_msd_rgb", rgb, BLANK ? 0 : rom_word(10));

      // T6 reset during SHIFT cycle 4
      pulse(250);
      tick(3);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_en", rgb_en, 0);
      tick(1);
      rst_n = 1'b1;
      tick(12);
      check("post_rst_busy", busy, 0);
      probe(70, 0);
      check("post_rst_lsd", rgb, rom_word(6));

      // Leading-zero behaviour with score 7
      pulse(7);
      wait_idle();
      probe(70, 3);
      check("s7_lsd_en", rgb_en, 1);
      check("s7_lsd_rgb", rgb, rom_word(10854));
      probe(40, 3);
      check("s7_mid_en", rgb_en, BLANK ? 0 : 1);
      probe(5, 3);
      check("s7_msd_en", rgb_en, BLANK ? 0 : 1);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
